// File: rtl/mdbrot_plot_framebuffer_if.sv
// Plot write bus from the Mandelbrot engine plus the raster pixel stream toward scan-out.
// master = engine/display side, slave = framebuffer.
interface mdbrot_plot_framebuffer_if;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot;
  logic       pix_valid;
  logic       pix_ready;
  logic [2:0] pix_colour;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       pix_sof;
  logic       pix_eol;

  modport master (
    output plot_x, plot_y, plot_colour, plot, pix_ready,
    input  pix_valid, pix_colour, pix_x, pix_y, pix_sof, pix_eol
  );
  modport slave (
    input  plot_x, plot_y, plot_colour, plot, pix_ready,
    output pix_valid, pix_colour, pix_x, pix_y, pix_sof, pix_eol
  );
endinterface

// File: rtl/mdbrot_plot_framebuffer.sv
// 160x120x3 framebuffer fed by plot writes; clears on request and streams the frame
// out in raster order through a 2-entry (output + skid) buffer behind a 1-cycle RAM read.
module mdbrot_plot_framebuffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mdbrot_plot_framebuffer_if.slave    bus,
  input  logic                        clear,
  input  logic                        scan_start,
  output logic                        busy,
  output logic [15:0]                 plot_count,
  output logic [15:0]                 drop_count
);
  localparam int AW   = 15;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [7:0]    XMAX  = 8'(WIDTH);
  localparam logic [6:0]    YMAX  = 7'(HEIGHT);
  localparam logic [7:0]    XLAST = 8'(WIDTH - 1);
  localparam logic [6:0]    YLAST = 7'(HEIGHT - 1);
  localparam logic [AW-1:0] ALAST = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       sof;
    logic       eol;
  } tag_t;
  typedef struct packed {
    logic [2:0] colour;
    tag_t       tag;
  } pix_t;

  function automatic logic [AW-1:0] addr(input logic [7:0] x, input logic [6:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  state_t          state, state_nx;
  logic [AW-1:0]   clr_addr;
  logic [7:0]      rx;
  logic [6:0]      ry;
  logic            rd_done;
  logic            rd_issue;
  logic            rd_vld;
  tag_t            rd_tag;
  logic [2:0]      rd_q;
  pix_t            rd_pix;
  pix_t            out_q, skid_q;
  logic            out_vld, skid_vld;
  logic [1:0]      occ;
  logic            pop, last_pop;
  logic            plot_in_range, plot_ok;
  logic            we;
  logic [AW-1:0]   wa;
  logic [2:0]      wd;
  logic [2:0]      mem [NPIX];

  assign plot_in_range = (bus.plot_x < XMAX) && (bus.plot_y < YMAX);
  assign pop      = out_vld && bus.pix_ready;
  assign last_pop = pop && (out_q.tag.x == XLAST) && (out_q.tag.y == YLAST);
  // Slots held or already committed by an in-flight read; the pop frees one this cycle.
  assign occ      = 2'(out_vld) + 2'(skid_vld) + 2'(rd_vld);

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clear) state_nx = CLEAR;
               else if (scan_start) state_nx = SCAN;
      CLEAR:   if (clr_addr == ALAST) state_nx = IDLE;
      SCAN:    if (last_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    plot_ok  = bus.plot && plot_in_range && (state != CLEAR);
    we       = plot_ok;
    wa       = addr(bus.plot_x, bus.plot_y);
    wd       = bus.plot_colour;
    rd_issue = 1'b0;
    case (state)
      // First read goes out with scan_start so pixel (0,0) is presented two cycles later.
      IDLE:    rd_issue = scan_start && !clear;
      CLEAR:   begin we = 1'b1; wa = clr_addr; wd = 3'd0; end
      SCAN:    rd_issue = !rd_done && ((occ - 2'(pop)) < 2'd2);
      default: rd_issue = 1'b0;
    endcase
  end

  // ---- counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      drop_count <= '0;
    end else if (bus.plot) begin
      if (plot_ok) plot_count <= plot_count + 16'd1;
      else         drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
    else                     clr_addr <= '0;
  end

  // ---- raster read pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx      <= '0;
      ry      <= '0;
      rd_done <= 1'b0;
    end else if (rd_issue) begin
      if (rx == XLAST) begin
        rx <= '0;
        if (ry == YLAST) rd_done <= 1'b1;
        else             ry      <= ry + 7'd1;
      end else begin
        rx <= rx + 8'd1;
      end
    end else if (state == IDLE) begin
      rx      <= '0;
      ry      <= '0;
      rd_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_tag <= '0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) rd_tag <= '{x: rx, y: ry, sof: (rx == 8'd0) && (ry == 7'd0), eol: (rx == XLAST)};
    end
  end

  // RAM: non-blocking write/read in one block gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (we)       mem[wa] <= wd;
    if (rd_issue) rd_q    <= mem[addr(rx, ry)];
  end

  assign rd_pix = '{colour: rd_q, tag: rd_tag};

  // ---- output register + skid ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (!out_vld || pop) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= rd_vld;
        if (rd_vld) skid_q <= rd_pix;
      end else begin
        out_vld <= rd_vld;
        if (rd_vld) out_q <= rd_pix;
      end
    end else if (rd_vld) begin
      skid_q   <= rd_pix;
      skid_vld <= 1'b1;
    end
  end

  assign bus.pix_valid  = out_vld;
  assign bus.pix_colour = out_q.colour;
  assign bus.pix_x      = out_q.tag.x;
  assign bus.pix_y      = out_q.tag.y;
  assign bus.pix_sof    = out_q.tag.sof;
  assign bus.pix_eol    = out_q.tag.eol;
endmodule
